// File: rtl/booth_operand_loader.sv
// booth_operand_loader: front end of the Booth multiplier.
// Debounces START, captures the switch operands, issues one o_start per press,
// then waits for i_rdy to rise or for the timeout to expire.
// Optional feature macro: LOADER_ZERO_SKIP_EN. When it is defined, a zero operand
// skips the launch and raises o_zero.
module booth_operand_loader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_btn_start,
    input  logic [WIDTH-1:0] i_sw_multiplier,
    input  logic [WIDTH-1:0] i_sw_multiplicand,
    input  logic             i_rdy,
    output logic             o_start,
    output logic [WIDTH-1:0] o_multiplier,
    output logic [WIDTH-1:0] o_multiplicand,
    output logic             o_busy,
    output logic             o_done,
`ifdef LOADER_ZERO_SKIP_EN
    output logic             o_zero,
`endif
    output logic             o_err
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_RELEASE
    } state_t;

    state_t            r_state, w_next;
    logic              r_sync1, r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_btn_stable, r_btn_prev;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_rdy_q;
    logic              r_done, r_err;
    logic              w_press, w_load_en;
    logic              w_set_done, w_set_err, w_set_zero;

    assign w_press   = r_btn_stable & ~r_btn_prev;
    assign w_load_en = (r_state == S_IDLE) && w_press;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_start;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt     <= '0;
            r_btn_stable <= 1'b0;
            r_btn_prev   <= 1'b0;
        end else begin
            r_btn_prev <= r_btn_stable;
            if (r_sync2 == r_btn_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_btn_stable <= r_sync2;
                r_db_cnt     <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic and the events that set the completion flags.
    always_comb begin
        w_next     = r_state;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        w_set_zero = 1'b0;
        case (r_state)
            S_IDLE:   if (w_press) w_next = S_LOAD;
`ifdef LOADER_ZERO_SKIP_EN
            S_LOAD: begin
                if (o_multiplier == '0 || o_multiplicand == '0) begin
                    w_next     = S_RELEASE;
                    w_set_done = 1'b1;
                    w_set_zero = 1'b1;
                end else begin
                    w_next = S_LAUNCH;
                end
            end
`else
            S_LOAD:   w_next = S_LAUNCH;
`endif
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                // A rising edge of i_rdy wins over a timeout that expires in the same cycle.
                if (i_rdy && !r_rdy_q) begin
                    w_next     = S_RELEASE;
                    w_set_done = 1'b1;
                end else if (r_to_cnt == TO_MAX) begin
                    w_next    = S_RELEASE;
                    w_set_err = 1'b1;
                end
            end
            S_RELEASE: if (!r_btn_stable) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Operands are captured on the edge into LOAD, so they are valid one cycle before o_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_multiplier   <= '0;
            o_multiplicand <= '0;
        end else if (w_load_en) begin
            o_multiplier   <= i_sw_multiplier;
            o_multiplicand <= i_sw_multiplicand;
        end
    end

    // Timeout counter: cleared in LAUNCH, counts in WAIT_RDY, saturates at its limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_rdy_q  <= 1'b0;
        end else begin
            r_rdy_q <= i_rdy;
            if (r_state == S_LAUNCH)
                r_to_cnt <= '0;
            else if (r_state == S_WAIT && r_to_cnt != TO_MAX)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Completion flags are sticky until the next LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_load_en) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_set_done) r_done <= 1'b1;
            if (w_set_err)  r_err  <= 1'b1;
        end
    end

`ifdef LOADER_ZERO_SKIP_EN
    // The zero-skip flag follows the same sticky rule as o_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            o_zero <= 1'b0;
        else if (w_load_en)  o_zero <= 1'b0;
        else if (w_set_zero) o_zero <= 1'b1;
    end
`else
    logic w_zero_unused;
    assign w_zero_unused = w_set_zero;
`endif

    assign o_start = (r_state == S_LAUNCH);
    assign o_busy  = (r_state == S_LOAD) || (r_state == S_LAUNCH) || (r_state == S_WAIT);
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_booth_operand_loader.sv
// Directed bench for booth_operand_loader, using DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=16.
module tb_booth_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_btn_start = 1'b0;
    logic [7:0] i_sw_multiplier = '0;
    logic [7:0] i_sw_multiplicand = '0;
    logic       i_rdy = 1'b0;
    logic       o_start;
    logic [7:0] o_multiplier, o_multiplicand;
    logic       o_busy, o_done, o_err;
`ifdef LOADER_ZERO_SKIP_EN
    logic       o_zero;
`endif

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int base;
    logic prev_start = 1'b0;
    logic dbl_start  = 1'b0;

    booth_operand_loader #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_btn_start      (i_btn_start),
        .i_sw_multiplier  (i_sw_multiplier),
        .i_sw_multiplicand(i_sw_multiplicand),
        .i_rdy            (i_rdy),
        .o_start          (o_start),
        .o_multiplier     (o_multiplier),
        .o_multiplicand   (o_multiplicand),
        .o_busy           (o_busy),
        .o_done           (o_done),
`ifdef LOADER_ZERO_SKIP_EN
        .o_zero           (o_zero),
`endif
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    // Count launch pulses and flag any pulse that lasts two cycles.
    always @(negedge clk) begin
        if (o_start) start_cnt++;
        if (o_start && prev_start) dbl_start = 1'b1;
        prev_start = o_start;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (!o_start && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_start_seen"}, o_start, 1);
    endtask

    task automatic rdy_pulse();
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
    endtask

    task automatic release_btn();
        i_btn_start = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        // 1: reset state with random inputs, then an idle button
        i_btn_start       = 1'($urandom);
        i_sw_multiplier   = 8'($urandom);
        i_sw_multiplicand = 8'($urandom);
        i_rdy             = 1'($urandom);
        repeat (3) tick();
        chk("rst_start", o_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ops", {o_multiplier, o_multiplicand}, 0);
        i_btn_start = 1'b0;
        i_rdy       = 1'b0;
        rst         = 1'b1;
        repeat (20) tick();
        chk("idle_no_start", start_cnt, 0);

        // 2: clean press with operands 7 and -3
        i_sw_multiplier   = 8'd7;
        i_sw_multiplicand = 8'hFD;
        i_btn_start       = 1'b1;
        wait_start("t2");
        chk("t2_ops_at_start", {o_multiplier, o_multiplicand}, 16'h07FD);
        chk("t2_busy", o_busy, 1);
        repeat (9) tick();
        i_sw_multiplier = 8'd99;
        chk("t2_ops_mid", {o_multiplier, o_multiplicand}, 16'h07FD);
        rdy_pulse();
        chk("t2_done", o_done, 1);
        chk("t2_notbusy", o_busy, 0);
        chk("t2_noerr", o_err, 0);
        chk("t2_one_start", start_cnt, 1);
        release_btn();
        chk("t2_done_held", o_done, 1);
        chk("t2_ops_idle", {o_multiplier, o_multiplicand}, 16'h07FD);

        // 3a: short bursts never launch
        base = start_cnt;
        repeat (2) begin
            i_btn_start = 1'b1; repeat (2) tick();
            i_btn_start = 1'b0; repeat (2) tick();
        end
        repeat (8) tick();
        i_btn_start = 1'b1; repeat (3) tick();
        i_btn_start = 1'b0; repeat (10) tick();
        chk("t3_bursts_no_start", start_cnt - base, 0);
        // 3b: bounce, then hold; exactly one launch
        i_sw_multiplier   = 8'h80;
        i_sw_multiplicand = 8'h7F;
        repeat (2) begin
            i_btn_start = 1'b1; repeat (2) tick();
            i_btn_start = 1'b0; repeat (2) tick();
        end
        i_btn_start = 1'b1;
        wait_start("t3");
        chk("t3_ops", {o_multiplier, o_multiplicand}, 16'h807F);
        repeat (4) tick();
        rdy_pulse();
        repeat (10) tick();
        chk("t3_one_start", start_cnt - base, 1);
        chk("t3_done", o_done, 1);
        release_btn();

        // 4: i_rdy stuck high leads to a timeout
        base  = start_cnt;
        i_rdy = 1'b1;
        i_btn_start = 1'b1;
        wait_start("t4");
        tick();
        repeat (15) tick();
        chk("t4_err_not_yet", o_err, 0);
        chk("t4_busy_wait", o_busy, 1);
        tick();
        chk("t4_err", o_err, 1);
        chk("t4_no_done", o_done, 0);
        chk("t4_notbusy", o_busy, 0);
        repeat (5) tick();
        chk("t4_held_no_relaunch", start_cnt - base, 1);
        release_btn();
        chk("t4_err_sticky", o_err, 1);
        i_rdy = 1'b0;
        i_btn_start = 1'b1;
        wait_start("t4b");
        chk("t4_err_cleared", o_err, 0);
        repeat (3) tick();
        rdy_pulse();
        chk("t4b_done", o_done, 1);
        release_btn();

        // 5: changes and bounces while in WAIT_RDY are ignored; reset in WAIT_RDY
        base = start_cnt;
        i_sw_multiplier   = 8'd3;
        i_sw_multiplicand = 8'd4;
        i_btn_start = 1'b1;
        wait_start("t5");
        repeat (2) tick();
        i_sw_multiplier   = 8'd11;
        i_sw_multiplicand = 8'd12;
        i_btn_start = 1'b0; repeat (3) tick();
        i_btn_start = 1'b1; repeat (5) tick();
        chk("t5_ops_unchanged", {o_multiplier, o_multiplicand}, 16'h0304);
        chk("t5_one_start", start_cnt - base, 1);
        chk("t5_busy", o_busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_ops", {o_multiplier, o_multiplicand}, 0);
        chk("t5_rst_done", o_done, 0);
        i_btn_start = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        // reset asserted during LAUNCH drops o_start at once
        i_btn_start = 1'b1;
        wait_start("t5b");
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_start", o_start, 0);
        i_btn_start = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // 6: zero operand
        base = start_cnt;
        i_sw_multiplier   = 8'd0;
        i_sw_multiplicand = 8'd5;
        i_btn_start = 1'b1;
`ifdef LOADER_ZERO_SKIP_EN
        repeat (20) tick();
        chk("t6_no_start", start_cnt - base, 0);
        chk("t6_zero", o_zero, 1);
        chk("t6_done", o_done, 1);
`else
        wait_start("t6");
        chk("t6_ops", {o_multiplier, o_multiplicand}, 16'h0005);
        repeat (3) tick();
        rdy_pulse();
        chk("t6_done", o_done, 1);
        chk("t6_one_start", start_cnt - base, 1);
`endif
        release_btn();

        chk("no_double_start", dbl_start, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
